core_mul: RTL and testbench

//  Multi-cycle integer multiplier/multiply-accumulator; the responder at the far end of the core_control
//  mul_* request interface. Latches operands on mul_start and computes a 64-bit result from a*b plus an

---
 rtl/core_mul_pkg.sv | 19 +
 rtl/core_mul_step.sv | 22 ++
 rtl/core_mul.sv | 102 ++++++++++
 tb/tb_core_mul.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_mul_pkg.sv
// Shared types for the multi-cycle multiplier: word/dword aliases, FSM encoding
// and the operand magnitude helper used when latching signed operands.
package core_mul_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } mul_state_e;

  // |v| as an unsigned word; -0x80000000 wraps to 0x80000000, which is exactly 2^31.
  function automatic word_t magnitude(input word_t v, input logic is_signed);
    return (is_signed && v[31]) ? word_t'(-v) : v;
  endfunction

endpackage

// File: rtl/core_mul_step.sv
// One multiply iteration: adds multiplicand * slice, shifted into place, to the
// running 64-bit accumulator. Purely combinational.
module core_mul_step
  import core_mul_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  dword_t               acc_in,
  input  word_t                mcand,
  input  logic [STEP_BITS-1:0] slice,
  input  logic [5:0]           shift,
  output dword_t               acc_out
);

  dword_t partial;

  always_comb begin
    partial = dword_t'(mcand) * dword_t'(slice);
    acc_out = acc_in + (partial << shift);
  end

endmodule

// File: rtl/core_mul.sv
// Multi-cycle signed/unsigned 32x32->64 multiplier with optional 32/64-bit addend.
// Retires STEP_BITS multiplier bits per cycle, then applies sign and addend in FIX.
module core_mul
  import core_mul_pkg::*;
#(
  parameter int STEP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_start,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  input  logic [31:0] mul_c_hi,
  input  logic [31:0] mul_c_lo,
  input  logic        mul_add,
  input  logic        mul_long,
  input  logic        mul_signed,
  output logic        mul_ready,
  output logic [31:0] mul_q_hi,
  output logic [31:0] mul_q_lo
);

  localparam int         N    = 32 / STEP_BITS;
  localparam logic [5:0] LAST = 6'(N - 1);

  // Handshake: a request is taken on any clock edge where mul_ready=1 and
  // mul_start=1; mul_ready stays low until q is updated, and starts seen while
  // low are dropped. q holds its value until the FIX of the next request.
  mul_state_e state, state_next;

  logic [5:0]           cnt;
  logic [5:0]           shift;
  logic [STEP_BITS-1:0] slice;
  word_t                a_mag, b_mag;
  dword_t               c64, acc, acc_next, q;
  logic                 neg, add;

  assign shift = 6'(cnt * STEP_BITS);
  assign slice = STEP_BITS'(b_mag >> shift);

  core_mul_step #(.STEP_BITS(STEP_BITS)) u_step (
    .acc_in  (acc),
    .mcand   (a_mag),
    .slice   (slice),
    .shift   (shift),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag <= '0;
      b_mag <= '0;
      c64   <= '0;
      neg   <= 1'b0;
      add   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      unique case (state)
        IDLE: if (mul_start) begin
          a_mag <= magnitude(mul_a, mul_signed);
          b_mag <= magnitude(mul_b, mul_signed);
          neg   <= mul_signed & (mul_a[31] ^ mul_b[31]);
          c64   <= mul_long ? {mul_c_hi, mul_c_lo} : {32'b0, mul_c_lo};
          add   <= mul_add;
          acc   <= '0;
          cnt   <= '0;
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
        end
        FIX: q <= (neg ? -acc : acc) + (add ? c64 : '0);
        default: ;
      endcase
    end
  end

  assign mul_q_hi = q[63:32];
  assign mul_q_lo = q[31:0];

endmodule

// File: tb/tb_core_mul.sv
// Directed and randomised checks of core_mul, run on four instances
// (STEP_BITS = 1, 2, 4, 8) that share one set of inputs.
module tb_core_mul;

  logic        clk, rst_n, mul_start;
  logic [31:0] mul_a, mul_b, mul_c_hi, mul_c_lo;
  logic        mul_add, mul_long, mul_signed;
  logic [3:0]  rdy;
  logic [31:0] qh [4];
  logic [31:0] ql [4];

  int total = 0;
  int bad   = 0;
  int lowcnt;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    core_mul #(.STEP_BITS(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mul_start  (mul_start),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_c_hi   (mul_c_hi),
      .mul_c_lo   (mul_c_lo),
      .mul_add    (mul_add),
      .mul_long   (mul_long),
      .mul_signed (mul_signed),
      .mul_ready  (rdy[g]),
      .mul_q_hi   (qh[g]),
      .mul_q_lo   (ql[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 4; i++)
      check64($sformatf("%s_sb%0d", tag, 1 << i), {qh[i], ql[i]}, exp);
  endtask

  task automatic set_ops(input logic [31:0] a, b, chi, clo, input logic add, lng, sgn);
    mul_a = a; mul_b = b; mul_c_hi = chi; mul_c_lo = clo;
    mul_add = add; mul_long = lng; mul_signed = sgn;
  endtask

  // Waits until every instance is idle; counts cycles the STEP_BITS=2 instance was busy.
  task automatic wait_all(output int low);
    logic ok;
    ok  = 1'b0;
    low = 0;
    for (int k = 0; k < 200; k++) begin
      if (!rdy[1]) low++;
      if (&rdy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL ready_timeout observed=%b expected=1111", rdy);
    end
  endtask

  task automatic run_op(input logic [31:0] a, b, chi, clo, input logic add, lng, sgn);
    set_ops(a, b, chi, clo, add, lng, sgn);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    wait_all(lowcnt);
  endtask

  function automatic logic [63:0] ref_model(input logic [31:0] a, b, chi, clo,
                                            input logic add, lng, sgn);
    logic [63:0] ea, eb, c;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    c  = add ? (lng ? {chi, clo} : {32'b0, clo}) : 64'd0;
    return ea * eb + c;
  endfunction

  initial begin
    logic [31:0] ra, rb, rch, rcl;
    logic        radd, rlng, rsgn;

    rst_n = 1'b0;
    mul_start = 1'b0;
    set_ops(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check64("reset_ready", 64'(rdy), 64'hF);
    check_all("reset_q", 64'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned max * max, with busy-cycle count on the default instance.
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check_all("umax", 64'hFFFFFFFE_00000001);
    check64("latency", 64'(lowcnt), 64'd17);

    // Signed -2*3; q must hold the previous result while busy.
    set_ops(32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    repeat (3) tick();
    check64("q_hold", {qh[1], ql[1]}, 64'hFFFFFFFE_00000001);
    wait_all(lowcnt);
    check_all("sneg", 64'hFFFFFFFF_FFFFFFFA);

    run_op(32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_all("smin", 64'h40000000_00000000);

    run_op(32'd3, 32'd5, 32'hDEADBEEF, 32'd7, 1'b1, 1'b0, 1'b0);
    check_all("short_mac", 64'd22);

    run_op(32'd1, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    check_all("long_carry", 64'h00000001_00000000);

    run_op(32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    check_all("long_wrap", 64'd0);

    // Start held high while busy with operands changing: only 2*3 counts.
    set_ops(32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    mul_start = 1'b1;
    tick();
    for (int k = 0; k < 100 && !rdy[1]; k++) begin
      mul_a = $urandom_range(1, 1000);
      mul_b = $urandom_range(1, 1000);
      tick();
    end
    mul_start = 1'b0;
    check64("held_start", {qh[1], ql[1]}, 64'd6);
    wait_all(lowcnt);

    // Back-to-back: new start presented as soon as ready returns.
    set_ops(32'd7, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    wait_all(lowcnt);
    check_all("b2b_first", 64'd63);
    set_ops(32'd11, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    check64("b2b_busy", 64'(rdy[1]), 64'd0);
    wait_all(lowcnt);
    check_all("b2b_second", 64'd143);

    // Asynchronous reset in the middle of MUL.
    set_ops(32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check64("mid_reset_ready", 64'(rdy), 64'hF);
    check_all("mid_reset_q", 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op(32'd6, 32'd7, 32'd0, 32'd100, 1'b1, 1'b0, 1'b0);
    check_all("after_reset", 64'd142);

    // Randomised operands and modes against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rch  = $urandom;
      rcl  = $urandom;
      radd = 1'($urandom_range(0, 1));
      rlng = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'd0;
      run_op(ra, rb, rch, rcl, radd, rlng, rsgn);
      check_all($sformatf("rand%0d", i), ref_model(ra, rb, rch, rcl, radd, rlng, rsgn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
